// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
// Helpers operate on a fixed-width vector so one definition serves any NREQ up to ARB_MAX_REQ.
package rr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int ARB_MAX_REQ = 64;
  typedef logic [ARB_MAX_REQ-1:0] arb_vec_t;

  // Binary index of a one-hot vector; zero input yields 0.
  function automatic int unsigned onehot2bin(input arb_vec_t oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

  // Thermometer with every bit strictly above idx set.
  function automatic arb_vec_t above_mask(input int unsigned idx);
    arb_vec_t m;
    m = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      m[i] = (unsigned'(i) > idx);
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Lowest-index-first priority encoder: one-hot of the lowest set bit plus an any flag.
// Purely combinational, zero latency.
module rr_prio_enc #(
  parameter int NREQ = 8
) (
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] onehot_o,
  output logic            any_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = req_i & (~req_i + NREQ'(1));
  assign any_o    = |req_i;

endmodule

// File: rtl/rr_arbiter_pkt.sv
// N-way round-robin arbiter with zero-latency grant, held stable while out_ready_i is low;
// with LOCK_PKT=1 the owner keeps the grant from its first beat through its accepted eop beat.
module rr_arbiter_pkt
  import rr_arb_pkg::*;
#(
  parameter  int NREQ     = 8,
  parameter  int LOCK_PKT = 1,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] req_eop_i,
  input  logic            out_ready_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_id_o,
  output logic            grant_valid_o,
  output logic            grant_eop_o,
  output logic            locked_o
);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [IDW-1:0]  owner_q, owner_d;

  logic [NREQ-1:0] masked_oh, unmasked_oh, idle_grant, lock_grant, grant;
  logic            masked_any, unmasked_any;
  logic [IDW-1:0]  grant_id;
  logic            grant_valid, grant_eop, accept, rel;

  rr_prio_enc #(.NREQ(NREQ)) u_enc_masked (
    .req_i    (req_i & mask_q),
    .onehot_o (masked_oh),
    .any_o    (masked_any)
  );

  rr_prio_enc #(.NREQ(NREQ)) u_enc_unmasked (
    .req_i    (req_i),
    .onehot_o (unmasked_oh),
    .any_o    (unmasked_any)
  );

  assign idle_grant = masked_any ? masked_oh : unmasked_oh;
  // While locked only the owner can be granted, and only while it presents a beat.
  assign lock_grant = (NREQ'(1) << owner_q) & req_i;

  assign grant       = (state_q == ARB_LOCKED) ? lock_grant : idle_grant;
  assign grant_valid = (state_q == ARB_LOCKED) ? (|lock_grant) : unmasked_any;
  assign grant_id    = IDW'(onehot2bin(arb_vec_t'(grant)));
  assign grant_eop   = |(grant & req_eop_i);
  assign accept      = grant_valid & out_ready_i;
  assign rel         = accept & (grant_eop | (LOCK_PKT == 0));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          if (rel) begin
            mask_d = NREQ'(above_mask(32'(grant_id)));
          end else begin
            state_d = ARB_LOCKED;
            owner_d = grant_id;
          end
        end
      end
      ARB_LOCKED: begin
        if (rel) begin
          state_d = ARB_IDLE;
          mask_d  = NREQ'(above_mask(32'(owner_q)));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      mask_q  <= '1;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      owner_q <= owner_d;
    end
  end

  assign grant_o       = grant;
  assign grant_id_o    = grant_id;
  assign grant_valid_o = grant_valid;
  assign grant_eop_o   = grant_eop;
  assign locked_o      = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_rr_arbiter_pkt.sv
// Directed bench driving a packet-locking and a per-beat arbiter from the same stimulus.
// Inputs change 1 time unit after posedge; outputs are compared 1 unit later.
module tb_rr_arbiter_pkt;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, req_eop;
  logic       out_ready;

  logic [7:0] g1, g0;
  logic [2:0] id1, id0;
  logic       v1, v0, e1, e0, l1, l0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter_pkt #(.NREQ(8), .LOCK_PKT(1)) dut_lock (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_eop_i(req_eop), .out_ready_i(out_ready),
    .grant_o(g1), .grant_id_o(id1), .grant_valid_o(v1), .grant_eop_o(e1), .locked_o(l1)
  );

  rr_arbiter_pkt #(.NREQ(8), .LOCK_PKT(0)) dut_beat (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_eop_i(req_eop), .out_ready_i(out_ready),
    .grant_o(g0), .grant_id_o(id0), .grant_valid_o(v0), .grant_eop_o(e0), .locked_o(l0)
  );

  a_onehot1: assert property (@(posedge clk) disable iff (rst) $onehot0(g1))
    else $error("FAIL assert_onehot_lock grant=%b", g1);
  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(g0))
    else $error("FAIL assert_onehot_beat grant=%b", g0);
  a_noreq1: assert property (@(posedge clk) disable iff (rst) (g1 & ~req) == 8'h00)
    else $error("FAIL assert_noreq_lock grant=%b req=%b", g1, req);
  a_noreq0: assert property (@(posedge clk) disable iff (rst) (g0 & ~req) == 8'h00)
    else $error("FAIL assert_noreq_beat grant=%b req=%b", g0, req);
  a_stable1: assert property (@(posedge clk) disable iff (rst)
      (v1 && !out_ready) |=> (g1 == $past(g1)) || (($past(g1) & req) == 8'h00))
    else $error("FAIL assert_stable_lock grant=%b", g1);
  a_stable0: assert property (@(posedge clk) disable iff (rst)
      (v0 && !out_ready) |=> (g0 == $past(g0)) || (($past(g0) & req) == 8'h00))
    else $error("FAIL assert_stable_beat grant=%b", g0);

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; req_eop = 8'h00; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; req_eop = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({g1, id1, v1, e1, l1} !== 14'h0) begin
      failures++;
      $display("FAIL reset_lock got g=%b id=%0d v=%b e=%b l=%b want all zero", g1, id1, v1, e1, l1);
    end
    checks++;
    if ({g0, id0, v0, e0, l0} !== 14'h0) begin
      failures++;
      $display("FAIL reset_beat got g=%b id=%0d v=%b e=%b l=%b want all zero", g0, id0, v0, e0, l0);
    end
  endtask

  task automatic test_alternate();
    logic [2:0] exp_id;
    do_reset();
    req = 8'h05; req_eop = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_id = (k % 2 == 1) ? 3'd2 : 3'd0;
      checks++;
      if ({v1, id1, l1, g1} !== {1'b1, exp_id, 1'b0, 8'h01 << exp_id}) begin
        failures++;
        $display("FAIL alternate_lock k=%0d got v=%b id=%0d l=%b g=%b want id=%0d", k, v1, id1, l1, g1, exp_id);
      end
      checks++;
      if ({v0, id0, l0, g0} !== {1'b1, exp_id, 1'b0, 8'h01 << exp_id}) begin
        failures++;
        $display("FAIL alternate_beat k=%0d got v=%b id=%0d l=%b g=%b want id=%0d", k, v0, id0, l0, g0, exp_id);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_rotation();
    logic [2:0] exp_id;
    do_reset();
    req = 8'hFF; req_eop = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      #1;
      exp_id = 3'(k % 8);
      checks++;
      if ({v1, id1, l1} !== {1'b1, exp_id, 1'b0}) begin
        failures++;
        $display("FAIL rotation_lock k=%0d got v=%b id=%0d l=%b want id=%0d", k, v1, id1, l1, exp_id);
      end
      checks++;
      if ({v0, id0, l0} !== {1'b1, exp_id, 1'b0}) begin
        failures++;
        $display("FAIL rotation_beat k=%0d got v=%b id=%0d l=%b want id=%0d", k, v0, id0, l0, exp_id);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'h04; req_eop = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({v1, id1, v0, id0} !== {1'b1, 3'd2, 1'b1, 3'd2}) begin
        failures++;
        $display("FAIL single_req k=%0d got lock v=%b id=%0d beat v=%b id=%0d want id=2", k, v1, id1, v0, id0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic exp_l;
    do_reset();
    req = 8'h03; req_eop = 8'hFF; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_l = (k > 0);
      checks++;
      if ({g1, l1, g0, l0} !== {8'h01, exp_l, 8'h01, exp_l}) begin
        failures++;
        $display("FAIL stall_hold k=%0d got g1=%b l1=%b g0=%b l0=%b want g=00000001 l=%b", k, g1, l1, g0, l0, exp_l);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({g1, l1, e1, g0, l0, e0} !== {8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL stall_accept got g1=%b l1=%b g0=%b l0=%b want g=00000001 l=1", g1, l1, g0, l0);
    end
    @(posedge clk); #1; #1;
    checks++;
    if ({v1, id1, l1, v0, id0, l0} !== {1'b1, 3'd1, 1'b0, 1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL stall_next got id1=%0d l1=%b id0=%0d l0=%b want id=1 l=0", id1, l1, id0, l0);
    end
  endtask

  task automatic test_packet_lock();
    int         ids1[5] = '{0, 0, 0, 0, 3};
    int         ids0[5] = '{0, 3, 0, 3, 0};
    logic [4:0] eop1 = 5'b11000;
    logic [4:0] lk1  = 5'b01110;
    logic [4:0] eop0 = 5'b01010;
    do_reset();
    req = 8'h09;
    for (int k = 0; k < 5; k++) begin
      req_eop = (k == 3) ? 8'h09 : 8'h08;
      #1;
      checks++;
      if ({v1, id1, e1, l1} !== {1'b1, 3'(ids1[k]), eop1[k], lk1[k]}) begin
        failures++;
        $display("FAIL pkt_lock k=%0d got v=%b id=%0d e=%b l=%b want id=%0d e=%b l=%b",
                 k, v1, id1, e1, l1, ids1[k], eop1[k], lk1[k]);
      end
      checks++;
      if ({v0, id0, e0, l0} !== {1'b1, 3'(ids0[k]), eop0[k], 1'b0}) begin
        failures++;
        $display("FAIL pkt_beat k=%0d got v=%b id=%0d e=%b l=%b want id=%0d e=%b l=0",
                 k, v0, id0, e0, l0, ids0[k], eop0[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_owner_drop();
    logic [7:0] reqs[6] = '{8'h09, 8'h08, 8'h08, 8'h09, 8'h09, 8'h09};
    int         ids1[6] = '{0, 0, 0, 0, 0, 3};
    int         ids0[6] = '{0, 3, 3, 0, 3, 0};
    logic [5:0] vld1 = 6'b111001;
    logic [5:0] lk1  = 6'b011110;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req = reqs[k];
      req_eop = (k == 4) ? 8'h01 : 8'h00;
      #1;
      checks++;
      if ({v1, id1, l1} !== {vld1[k], 3'(ids1[k]), lk1[k]}) begin
        failures++;
        $display("FAIL drop_lock k=%0d got v=%b id=%0d l=%b g=%b want v=%b id=%0d l=%b",
                 k, v1, id1, l1, g1, vld1[k], ids1[k], lk1[k]);
      end
      checks++;
      if ({v0, id0, l0} !== {1'b1, 3'(ids0[k]), 1'b0}) begin
        failures++;
        $display("FAIL drop_beat k=%0d got v=%b id=%0d l=%b want v=1 id=%0d l=0", k, v0, id0, l0, ids0[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_locked();
    do_reset();
    req = 8'h08; req_eop = 8'h00;
    #1;
    @(posedge clk); #1; #1;
    checks++;
    if ({id1, l1, id0, l0} !== {3'd3, 1'b1, 3'd3, 1'b0}) begin
      failures++;
      $display("FAIL pre_reset got id1=%0d l1=%b id0=%0d l0=%b want id=3 l1=1 l0=0", id1, l1, id0, l0);
    end
    rst = 1'b1; req = 8'h88;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({g1, l1, g0, l0} !== {8'h08, 1'b0, 8'h08, 1'b0}) begin
      failures++;
      $display("FAIL reset_locked got g1=%b l1=%b g0=%b l0=%b want g=00001000 l=0", g1, l1, g0, l0);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_full_rotation();
    test_back_to_back();
    test_stall();
    test_packet_lock();
    test_owner_drop();
    test_reset_locked();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
